// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with private HI/LO and a pipeline stall request.
// Optional divider datapath is guarded by `ifdef MULDIV_DIV_EN (disabled by default).
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             read_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_req
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t             state;
    logic [5:0]         count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_res;

    logic               sign_a_in, sign_b_in, accept;
    logic [WIDTH-1:0]   mag_a_in, mag_b_in;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;

    // Signed ops work on magnitudes; the result sign is restored in FIX.
    assign sign_a_in = !op[0] && operand_a[WIDTH-1];
    assign sign_b_in = !op[0] && operand_b[WIDTH-1];
    assign mag_a_in  = sign_a_in ? -operand_a : operand_a;
    assign mag_b_in  = sign_b_in ? -operand_b : operand_b;
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    assign prod      = neg_res ? -acc : acc;

`ifdef MULDIV_DIV_EN
    logic             is_div, sign_a, div_zero;
    logic [WIDTH-1:0] raw_a, rem;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic [WIDTH-1:0] quo, rem_fix;

    assign accept   = (state == IDLE) && start;
    assign rem_sh   = {rem, acc[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, mag_b};
    assign quo      = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = sign_a ? -rem : rem;
`else
    // Without the divider, DIV/DIVU are consumed in IDLE as no-ops.
    assign accept = (state == IDLE) && start && !op[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            acc     <= '0;
            mag_b   <= '0;
            neg_res <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state   <= RUN;
                    count   <= '0;
                    acc     <= {{WIDTH{1'b0}}, mag_a_in};
                    mag_b   <= mag_b_in;
                    neg_res <= sign_a_in ^ sign_b_in;
`ifdef MULDIV_DIV_EN
                    is_div   <= op[1];
                    sign_a   <= sign_a_in;
                    div_zero <= (operand_b == '0);
                    raw_a    <= operand_a;
                    rem      <= '0;
`endif
                end
                RUN: begin
                    count <= count + 6'd1;
                    if (count == LAST) state <= FIX;
`ifdef MULDIV_DIV_EN
                    // Restoring step: quotient bits shift into the low half of acc.
                    if (is_div) begin
                        if (!rem_diff[WIDTH]) begin
                            rem <= rem_diff[WIDTH-1:0];
                            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= rem_sh[WIDTH-1:0];
                            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
                        end
                    end else
`endif
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                end
                FIX: begin
                    state <= IDLE;
                    done  <= 1'b1;
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        if (div_zero) begin
                            hi <= raw_a;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo;
                        end
                    end else
`endif
                    begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign stall_req = busy && (start || read_hilo);
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {hi,lo} queued at issue, popped at done.
// Divide scenarios run when MULDIV_DIV_EN is defined; otherwise the disabled-divider path is checked.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, read_hilo;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b, hi, lo;
    logic        busy, done, stall_req;

    logic [63:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .read_hilo(read_hilo),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; read_hilo = 1'b0; op = MULT;
        operand_a = '0; operand_b = '0;
        repeat (2) @(negedge clk);
        read_hilo = 1'b1;
        #1;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_req); end
        read_hilo = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    // Issue one op, then check 33-cycle busy window, done pulse and result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv, input string name);
        int n;
        logic [63:0] e;
        exp_q.push_back(expv);
        @(negedge clk); start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (busy && n < 40) begin n++; @(negedge clk); end
        checks++; if (n !== 33) begin errors++; $display("FAIL %s_latency got %0d want 33", name, n); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done got %b want 1", name, done); end
        e = exp_q.pop_front();
        checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL %s_result got %h want %h", name, {hi, lo}, e); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b want 0", name, done); end
    endtask

    task automatic test_mult;
        run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max");
        run_op(MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, "mult_neg");
        run_op(MULT, 32'hFFFFFFF0, 32'hFFFFFFF0, 64'h00000000_00000100, "mult_negneg");
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div;
        run_op(DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div_neg");
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_ovf");
        run_op(DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, "divu");
        run_op(DIVU, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, "divu_zero");
    endtask
`else
    task automatic test_div_disabled;
        logic [63:0] old;
        old = {hi, lo};
        @(negedge clk); start = 1'b1; op = DIVU; operand_a = 32'd9; operand_b = 32'd3;
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nodiv_busy got %b want 0", busy); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL nodiv_done got %b want 0", done); end
        checks++; if ({hi, lo} !== old) begin errors++; $display("FAIL nodiv_hilo got %h want %h", {hi, lo}, old); end
    endtask
`endif

    // Held read_hilo and a held second start stall until busy drops; the start lands in the done cycle.
    task automatic test_back_to_back;
        int n, bad_stall, bad_hold;
        logic [63:0] old, e;
        old = {hi, lo};
        exp_q.push_back(64'd15);
        @(negedge clk); start = 1'b1; op = MULTU; operand_a = 32'd3; operand_b = 32'd5;
        @(negedge clk); op = MULT; operand_a = 32'hFFFFFFFE; operand_b = 32'd6;
        n = 0; bad_stall = 0; bad_hold = 0;
        while (busy && n < 40) begin
            n++;
            if (n >= 5) read_hilo = 1'b1;
            #1;
            if (stall_req !== 1'b1) bad_stall++;
            if ({hi, lo} !== old) bad_hold++;
            @(negedge clk);
        end
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", n); end
        checks++; if (bad_stall !== 0) begin errors++; $display("FAIL b2b_stall_low got %0d cycles want 0", bad_stall); end
        checks++; if (bad_hold !== 0) begin errors++; $display("FAIL b2b_hilo_early got %0d cycles want 0", bad_hold); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL b2b_stall_done got %b want 0", stall_req); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
        e = exp_q.pop_front();
        checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL b2b_first got %h want %h", {hi, lo}, e); end
        read_hilo = 1'b0;
        exp_q.push_back(64'hFFFFFFFF_FFFFFFF4);
        @(negedge clk); start = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", busy); end
        n = 1;
        @(negedge clk);
        while (busy && n < 40) begin n++; @(negedge clk); end
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b_second_latency got %0d want 33", n); end
        e = exp_q.pop_front();
        checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL b2b_second got %h want %h", {hi, lo}, e); end
    endtask

    task automatic test_reset_abort;
        int seen_done;
        @(negedge clk); start = 1'b1; op = MULTU; operand_a = 32'h1234; operand_b = 32'h5678;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo got %h want 0", {hi, lo}); end
        reset = 1'b0; start = 1'b0;
        seen_done = 0;
        repeat (40) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) seen_done++; end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", seen_done); end
    endtask

    initial begin
        test_reset;
        test_mult;
`ifdef MULDIV_DIV_EN
        test_div;
`else
        test_div_disabled;
`endif
        test_back_to_back;
        test_reset_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
